// File: rtl/imhotep_pkg.sv
// Shared types and widths for the imhotep load/store path.
package imhotep_pkg;

   localparam int XLEN      = 32;
   localparam int RAM_WIDTH = 12;

   typedef enum logic [1:0] {
      SIZE_B = 2'b00,
      SIZE_H = 2'b01,
      SIZE_W = 2'b10
   } mem_size_e;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'b00,
      ST_ACCESS = 2'b01,
      ST_WAIT   = 2'b10,
      ST_RESP   = 2'b11
   } lsu_state_e;

endpackage

// File: rtl/lsu_ram_align.sv
// Byte-lane steering for stores and shift/extend for loads; purely combinational.
module lsu_ram_align
   import imhotep_pkg::*;
(
   input  logic [1:0]      i_size,
   input  logic [1:0]      i_addr_lo,
   input  logic            i_unsigned,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [XLEN-1:0] i_rword,
   output logic [3:0]      o_be,
   output logic [XLEN-1:0] o_wdata,
   output logic [XLEN-1:0] o_rdata,
   output logic            o_misalign
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   function automatic logic [XLEN-1:0] extend(input logic [15:0] v,
                                              input logic        is_half,
                                              input logic        uns);
      logic [XLEN-1:0] r;
      if (is_half) r = {{(XLEN-16){v[15] & ~uns}}, v};
      else         r = {{(XLEN-8){v[7] & ~uns}}, v[7:0]};
      return r;
   endfunction

   assign w_half = i_addr_lo[1] ? i_rword[31:16] : i_rword[15:0];

   always_comb begin
      w_byte = i_rword[7:0];
      case (i_addr_lo)
         2'd1:    w_byte = i_rword[15:8];
         2'd2:    w_byte = i_rword[23:16];
         2'd3:    w_byte = i_rword[31:24];
         default: w_byte = i_rword[7:0];
      endcase
   end

   always_comb begin
      o_be       = 4'b0000;
      o_wdata    = i_wdata;
      o_rdata    = '0;
      o_misalign = 1'b0;
      case (i_size)
         SIZE_B: begin
            o_be    = 4'b0001 << i_addr_lo;
            o_wdata = {4{i_wdata[7:0]}};
            o_rdata = extend({8'h00, w_byte}, 1'b0, i_unsigned);
         end
         SIZE_H: begin
            o_be       = i_addr_lo[1] ? 4'b1100 : 4'b0011;
            o_wdata    = {2{i_wdata[15:0]}};
            o_rdata    = extend(w_half, 1'b1, i_unsigned);
            o_misalign = i_addr_lo[0];
         end
         SIZE_W: begin
            o_be       = 4'b1111;
            o_rdata    = i_rword;
            o_misalign = (i_addr_lo != 2'b00);
         end
         default: ;
      endcase
   end

endmodule

// File: rtl/lsu_ram.sv
// Request/response data RAM with wait states, byte lanes, load extension
// and fault reporting for the imhotep memory stage.
module lsu_ram
   import imhotep_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_STATES = 1
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic                 we_i,
   input  logic [1:0]           size_i,
   input  logic                 unsigned_i,
   input  logic [RAM_WIDTH-1:0] addr_i,
   input  logic [XLEN-1:0]      wdata_i,
   output logic                 rsp_valid_o,
   input  logic                 rsp_ready_i,
   output logic [XLEN-1:0]      rsp_data_o,
   output logic                 rsp_err_o
);

   localparam int         IDX_W     = $clog2(DEPTH_WORDS);
   localparam logic [2:0] WAIT_INIT = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

   lsu_state_e              r_state;
   logic [2:0]              r_cnt;
   logic                    r_we;
   logic [1:0]              r_size;
   logic                    r_uns;
   logic [RAM_WIDTH-1:0]    r_addr;
   logic [XLEN-1:0]         r_wdata;
   logic [XLEN-1:0]         r_rsp_data;
   logic                    r_rsp_err;
   logic [XLEN-1:0]         r_mem [DEPTH_WORDS];

   logic [RAM_WIDTH-3:0]    w_idx;
   logic [XLEN-1:0]         w_rword;
   logic [3:0]              w_be;
   logic [XLEN-1:0]         w_wdata;
   logic [XLEN-1:0]         w_ext;
   logic                    w_misalign;
   logic                    w_oor;
   logic                    w_err;

   assign w_idx   = r_addr[RAM_WIDTH-1:2];
   assign w_rword = r_mem[w_idx[IDX_W-1:0]];
   // Compared as int so a depth that fills the whole index range stays legal.
   assign w_oor   = int'(w_idx) >= DEPTH_WORDS;
   assign w_err   = (r_size == 2'b11) | w_misalign | w_oor;

   lsu_ram_align u_align (
      .i_size     (r_size),
      .i_addr_lo  (r_addr[1:0]),
      .i_unsigned (r_uns),
      .i_wdata    (r_wdata),
      .i_rword    (w_rword),
      .o_be       (w_be),
      .o_wdata    (w_wdata),
      .o_rdata    (w_ext),
      .o_misalign (w_misalign)
   );

   assign req_ready_o = reset_n & (r_state == ST_IDLE);
   assign rsp_valid_o = (r_state == ST_RESP);
   assign rsp_data_o  = r_rsp_data;
   assign rsp_err_o   = r_rsp_err;

   always_ff @(posedge clk) begin
      if (req_valid_i && req_ready_o) begin
         r_we    <= we_i;
         r_size  <= size_i;
         r_uns   <= unsigned_i;
         r_addr  <= addr_i;
         r_wdata <= wdata_i;
      end
   end

   // Commit edge: reset wins, so a store caught by reset never lands.
   always_ff @(posedge clk) begin
      if (reset_n && r_state == ST_ACCESS && r_we && !w_err) begin
         for (int b = 0; b < 4; b++) begin
            if (w_be[b]) r_mem[w_idx[IDX_W-1:0]][8*b +: 8] <= w_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= 3'd0;
         r_rsp_data <= '0;
         r_rsp_err  <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (req_valid_i) r_state <= ST_ACCESS;
            end
            ST_ACCESS: begin
               r_rsp_err  <= w_err;
               r_rsp_data <= (w_err || r_we) ? '0 : w_ext;
               if (WAIT_STATES > 0) begin
                  r_state <= ST_WAIT;
                  r_cnt   <= WAIT_INIT;
               end else begin
                  r_state <= ST_RESP;
               end
            end
            ST_WAIT: begin
               if (r_cnt == 3'd0) r_state <= ST_RESP;
               else               r_cnt   <= r_cnt - 3'd1;
            end
            ST_RESP: begin
               if (rsp_ready_i) r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_ram.sv
// Directed bench for lsu_ram: four instances cover 1, 0 and 7 wait states
// and a half-depth RAM for the out-of-range path.
module tb_lsu_ram;
   import imhotep_pkg::*;

   logic                 clk = 1'b0;
   logic                 reset_n;
   logic                 we;
   logic [1:0]           size;
   logic                 uns;
   logic [RAM_WIDTH-1:0] addr;
   logic [XLEN-1:0]      wdata;
   logic                 rsp_ready;
   logic [3:0]           req_valid;
   logic [3:0]           req_ready;
   logic [3:0]           rsp_valid;
   logic [3:0]           rsp_err;
   logic [XLEN-1:0]      rsp_data [4];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(1)) u_w1 (
      .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid[0]), .req_ready_o(req_ready[0]),
      .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
      .rsp_valid_o(rsp_valid[0]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[0]),
      .rsp_err_o(rsp_err[0]));

   lsu_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(0)) u_w0 (
      .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid[1]), .req_ready_o(req_ready[1]),
      .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
      .rsp_valid_o(rsp_valid[1]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[1]),
      .rsp_err_o(rsp_err[1]));

   lsu_ram #(.DEPTH_WORDS(1024), .WAIT_STATES(7)) u_w7 (
      .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid[2]), .req_ready_o(req_ready[2]),
      .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
      .rsp_valid_o(rsp_valid[2]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[2]),
      .rsp_err_o(rsp_err[2]));

   lsu_ram #(.DEPTH_WORDS(512), .WAIT_STATES(1)) u_d512 (
      .clk(clk), .reset_n(reset_n), .req_valid_i(req_valid[3]), .req_ready_o(req_ready[3]),
      .we_i(we), .size_i(size), .unsigned_i(uns), .addr_i(addr), .wdata_i(wdata),
      .rsp_valid_o(rsp_valid[3]), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data[3]),
      .rsp_err_o(rsp_err[3]));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, want 0x%08h", tag, act, exp);
      end
   endtask

   task automatic drive(input logic w, input logic [1:0] sz, input logic u, input int a,
                        input logic [31:0] wd);
      we    = w;
      size  = sz;
      uns   = u;
      addr  = RAM_WIDTH'(a);
      wdata = wd;
   endtask

   // Counts edges from accept until rsp_valid is seen, sampling #1 after each edge.
   task automatic wait_rsp(input int d, output int lat);
      lat = 0;
      while (!rsp_valid[d] && lat < 30) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   // One complete transaction with rsp_ready held high.
   task automatic txn(input string tag, input int d, input logic w, input logic [1:0] sz,
                      input logic u, input int a, input logic [31:0] wd,
                      input logic [31:0] exp_data, input logic exp_err, input int exp_lat);
      int guard;
      int lat;
      drive(w, sz, u, a, wd);
      req_valid[d] = 1'b1;
      guard = 0;
      while (!req_ready[d] && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      @(posedge clk); #1;
      req_valid[d] = 1'b0;
      wait_rsp(d, lat);
      chk({tag, "/lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "/err"}, {31'b0, rsp_err[d]}, {31'b0, exp_err});
      chk({tag, "/data"}, rsp_data[d], exp_data);
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      reset_n   = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 4'b0000;
      drive(1'b0, SIZE_W, 1'b0, 0, 32'h0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst/req_ready_low", {31'b0, req_ready[0]}, 32'd0);
      chk("rst/rsp_valid", {31'b0, rsp_valid[0]}, 32'd0);
      chk("rst/rsp_err", {31'b0, rsp_err[0]}, 32'd0);
      chk("rst/rsp_data", rsp_data[0], 32'h0);
      reset_n = 1'b1;
      #1;
      chk("rst/req_ready_high", {28'b0, req_ready}, 32'hF);

      // The RAM decodes only the low RAM_WIDTH address bits, so 0x3000 is word 0.
      txn("s1_st_w", 0, 1'b1, SIZE_W, 1'b0, 'h3000, 32'h76543210, 32'h0, 1'b0, 2);
      txn("s1_ld_w", 0, 1'b0, SIZE_W, 1'b0, 'h3000, 32'h0, 32'h76543210, 1'b0, 2);

      txn("s2_st_b", 0, 1'b1, SIZE_B, 1'b0, 'h3001, 32'h123456A5, 32'h0, 1'b0, 2);
      txn("s2_ld_bs", 0, 1'b0, SIZE_B, 1'b0, 'h3001, 32'h0, 32'hFFFFFFA5, 1'b0, 2);
      txn("s2_ld_bu", 0, 1'b0, SIZE_B, 1'b1, 'h3001, 32'h0, 32'h000000A5, 1'b0, 2);
      txn("s2_ld_w", 0, 1'b0, SIZE_W, 1'b0, 'h3000, 32'h0, 32'h7654A510, 1'b0, 2);

      txn("s3_ld_hs_pos", 0, 1'b0, SIZE_H, 1'b0, 'h3002, 32'h0, 32'h00007654, 1'b0, 2);
      txn("s3_st_h", 0, 1'b1, SIZE_H, 1'b0, 'h3002, 32'hABCD8001, 32'h0, 1'b0, 2);
      txn("s3_ld_hs", 0, 1'b0, SIZE_H, 1'b0, 'h3002, 32'h0, 32'hFFFF8001, 1'b0, 2);
      txn("s3_ld_hu", 0, 1'b0, SIZE_H, 1'b1, 'h3002, 32'h0, 32'h00008001, 1'b0, 2);
      txn("s3_ld_hs_lo", 0, 1'b0, SIZE_H, 1'b0, 'h3000, 32'h0, 32'hFFFFA510, 1'b0, 2);
      txn("s3_ld_bs_3", 0, 1'b0, SIZE_B, 1'b0, 'h3003, 32'h0, 32'hFFFFFF80, 1'b0, 2);

      txn("s4_st_w_mis", 0, 1'b1, SIZE_W, 1'b0, 'h3001, 32'hDEADBEEF, 32'h0, 1'b1, 2);
      txn("s4_chk1", 0, 1'b0, SIZE_W, 1'b0, 'h3000, 32'h0, 32'h8001A510, 1'b0, 2);
      txn("s4_ld_h_mis", 0, 1'b0, SIZE_H, 1'b0, 'h3003, 32'h0, 32'h0, 1'b1, 2);
      txn("s4_chk2", 0, 1'b0, SIZE_W, 1'b0, 'h3000, 32'h0, 32'h8001A510, 1'b0, 2);
      txn("s4_st_sz11", 0, 1'b1, 2'b11, 1'b0, 'h3000, 32'hFFFFFFFF, 32'h0, 1'b1, 2);
      txn("s4_chk3", 0, 1'b0, SIZE_W, 1'b0, 'h3000, 32'h0, 32'h8001A510, 1'b0, 2);
      txn("top_st_w", 0, 1'b1, SIZE_W, 1'b0, 'hFFC, 32'h0BADF00D, 32'h0, 1'b0, 2);
      txn("top_ld_w", 0, 1'b0, SIZE_W, 1'b0, 'hFFC, 32'h0, 32'h0BADF00D, 1'b0, 2);

      txn("oor_st_w", 3, 1'b1, SIZE_W, 1'b0, 'h7FC, 32'hCAFEF00D, 32'h0, 1'b0, 2);
      txn("oor_ld_w", 3, 1'b0, SIZE_W, 1'b0, 4 * 512, 32'h0, 32'h0, 1'b1, 2);
      txn("oor_st_hi", 3, 1'b1, SIZE_W, 1'b0, 'hFFC, 32'h11223344, 32'h0, 1'b1, 2);
      txn("oor_chk", 3, 1'b0, SIZE_W, 1'b0, 'h7FC, 32'h0, 32'hCAFEF00D, 1'b0, 2);

      // Backpressure with a second request parked on req_valid.
      rsp_ready = 1'b0;
      drive(1'b0, SIZE_W, 1'b0, 'h3000, 32'h0);
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      drive(1'b0, SIZE_B, 1'b1, 'h3001, 32'h0);
      wait_rsp(0, lat);
      chk("bp/lat", 32'(lat), 32'd2);
      chk("bp/data", rsp_data[0], 32'h8001A510);
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("bp/hold_valid", {31'b0, rsp_valid[0]}, 32'd1);
         chk("bp/hold_data", rsp_data[0], 32'h8001A510);
         chk("bp/req_ready", {31'b0, req_ready[0]}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp/after_hs_valid", {31'b0, rsp_valid[0]}, 32'd0);
      chk("bp/after_hs_ready", {31'b0, req_ready[0]}, 32'd1);
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      wait_rsp(0, lat);
      chk("bp/second_lat", 32'(lat), 32'd2);
      chk("bp/second_data", rsp_data[0], 32'h000000A5);
      @(posedge clk); #1;

      // Reset sampled on the commit edge of a store.
      drive(1'b1, SIZE_W, 1'b0, 'h3000, 32'h11111111);
      req_valid[0] = 1'b1;
      @(posedge clk); #1;
      req_valid[0] = 1'b0;
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk("rst6/req_ready_low", {31'b0, req_ready[0]}, 32'd0);
      reset_n = 1'b1;
      #1;
      chk("rst6/req_ready_high", {31'b0, req_ready[0]}, 32'd1);
      for (int i = 0; i < 3; i++) begin
         chk("rst6/no_rsp", {31'b0, rsp_valid[0]}, 32'd0);
         @(posedge clk); #1;
      end
      txn("rst6_ld_w", 0, 1'b0, SIZE_W, 1'b0, 'h3000, 32'h0, 32'h8001A510, 1'b0, 2);

      txn("w0_st_w", 1, 1'b1, SIZE_W, 1'b0, 'h3000, 32'h76543210, 32'h0, 1'b0, 1);
      txn("w0_ld_w", 1, 1'b0, SIZE_W, 1'b0, 'h3000, 32'h0, 32'h76543210, 1'b0, 1);
      txn("w7_st_w", 2, 1'b1, SIZE_W, 1'b0, 'h3000, 32'h76543210, 32'h0, 1'b0, 8);
      txn("w7_ld_w", 2, 1'b0, SIZE_W, 1'b0, 'h3000, 32'h0, 32'h76543210, 1'b0, 8);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
